hazard_stall_ctrl: RTL and testbench
====================================

// Module: hazard_stall_ctrl
// PURPOSE
//  Pipeline sequencer for the 16-bit 5-stage CPU: drives PC/IF-ID write enables and the IF-ID / ID-EX flush
//  controls. Detects load-use hazards (one bubble), freezes the front end for multi-cycle mul/div, and
//  squashes wrong-path instructions on taken branches. Sits beside the ID stage; flush outputs feed the
//  IF/ID and ID/EX buffers. Keeps a saturating stall-cycle counter for performance debug.
// PARAMETERS
//  MULDIV_CYCLES  4   cycles the mul/div unit needs in EX (legal range 1..255)
// PORTS
//  clock         in   1   system clock, rising edge
//  reset         in   1   asynchronous, active-low reset
//  id_valid      in   1   ID stage holds a real (non-bubble) instruction
//  id_RR1        in   4   ID source register 1 address
//  id_RR2        in   4   ID source register 2 address
//  id_readRR1    in   1   ID instruction actually reads RR1
//  id_readRR2    in   1   ID instruction actually reads RR2
//  id_isMulDiv   in   1   ID instruction is multiply/divide
//  ex_memRead    in   1   ID/EX buffer memRead (load in EX)
//  ex_wAddr      in   4   ID/EX buffer destination address
//  ex_branchTaken in  1   branch/jump resolved taken in EX this cycle
//  statClear     in   1   synchronous clear of stallCount
//  pcWrite       out  1   PC update enable
//  ifidWrite     out  1   IF/ID buffer load enable
//  ifidFlush     out  1   zero IF/ID buffer at next edge
//  idexFlush     out  1   zero ID/EX buffer at next edge (bubble)
//  muldivBusy    out  1   controller in MULDIV state
//  ctrlState     out  2   current state encoding (debug)
//  stallCount    out  16  cycles with pcWrite==0, saturating
// BEHAVIOUR
//  - States (ctrlState): RUN=0, LOAD_STALL=1, MULDIV=2; 3 unused -> next RUN, outputs as RUN.
//  - State, mul/div down-counter, and stallCount are registered; control outputs are combinational from
//    state and inputs, effective in the same cycle as detection.
//  - luh = id_valid & ex_memRead & ((id_readRR1 & id_RR1==ex_wAddr) | (id_readRR2 & id_RR2==ex_wAddr)).
//    R0 is not special-cased.
//  - RUN, priority high->low:
//    . ex_branchTaken: pcWrite=1, ifidWrite=1, ifidFlush=1, idexFlush=1; next RUN. Overrides luh and mul/div.
//    . luh: pcWrite=0, ifidWrite=0, idexFlush=1, ifidFlush=0; next LOAD_STALL.
//    . id_valid & id_isMulDiv: pass instruction into ID/EX (all enables 1, no flush); next MULDIV,
//      counter <= MULDIV_CYCLES-1.
//    . else: pcWrite=1, ifidWrite=1, flushes 0; stay RUN.
//  - LOAD_STALL: enables 1, flushes 0. Next MULDIV (counter load as above) if id_valid & id_isMulDiv,
//    else RUN. luh is not re-evaluated because EX holds a bubble.
//  - MULDIV: pcWrite=0, ifidWrite=0, idexFlush=1, ifidFlush=0, muldivBusy=1.
//    . counter!=0: decrement.
//    . counter==0: next RUN.
//    . Front end is frozen exactly MULDIV_CYCLES cycles.
//    . ex_branchTaken is ignored in MULDIV and must not occur; the bench asserts this.
//  - stallCount: +1 on each cycle with pcWrite==0, holding at 16'hFFFF. statClear loads 0 and takes
//    priority over the increment.
//  - Reset (async, any state, including mid-MULDIV):
//    . state=RUN, counter=0, stallCount=0.
//    . outputs pcWrite=1, ifidWrite=1, ifidFlush=0, idexFlush=0, muldivBusy=0, ctrlState=0.
//    . First edge after release behaves as RUN.
// TESTING
//  1 ex_memRead=1, ex_wAddr=3, id_RR1=3, id_readRR1=1, id_valid=1 -> same cycle pcWrite=0, ifidWrite=0,
//    idexFlush=1; next cycle ctrlState=1, enables 1; stallCount=1.
//  2 Same as 1 but id_readRR1=0, or ex_wAddr=4 -> no stall, ctrlState stays 0, stallCount=0.
//  3 luh conditions plus ex_branchTaken=1 -> ifidFlush=idexFlush=1, pcWrite=1, ctrlState stays 0,
//    stallCount unchanged.
//  4 MULDIV_CYCLES=4, id_isMulDiv=1 in RUN -> 4 cycles with muldivBusy=1, pcWrite=0, idexFlush=1, then
//    ctrlState=0; stallCount +4. Back-to-back mul/div re-enters MULDIV directly.
//  5 Load-use where the ID instruction is a mul/div -> 1 bubble, LOAD_STALL, then 4 MULDIV cycles;
//    stallCount +5.
//  6 reset=0 in the 2nd MULDIV cycle -> immediately ctrlState=0, muldivBusy=0, pcWrite=1, stallCount=0.
//    Separately, 70000 stall cycles -> stallCount=16'hFFFF; statClear=1 -> 0 next edge.

Source files
------------

// File: rtl/hazard_stall_ctrl_if.sv
// Pipeline-control bundle between the ID-stage hazard sequencer and the pipeline buffers.
interface hazard_stall_ctrl_if;
    logic        id_valid;
    logic [3:0]  id_RR1;
    logic [3:0]  id_RR2;
    logic        id_readRR1;
    logic        id_readRR2;
    logic        id_isMulDiv;
    logic        ex_memRead;
    logic [3:0]  ex_wAddr;
    logic        ex_branchTaken;
    logic        statClear;
    logic        pcWrite;
    logic        ifidWrite;
    logic        ifidFlush;
    logic        idexFlush;
    logic        muldivBusy;
    logic [1:0]  ctrlState;
    logic [15:0] stallCount;

    // Pipeline side: supplies decode/EX status, consumes the control strobes.
    modport master (
        output id_valid, id_RR1, id_RR2, id_readRR1, id_readRR2, id_isMulDiv,
        output ex_memRead, ex_wAddr, ex_branchTaken, statClear,
        input  pcWrite, ifidWrite, ifidFlush, idexFlush, muldivBusy, ctrlState, stallCount
    );

    // Controller side.
    modport slave (
        input  id_valid, id_RR1, id_RR2, id_readRR1, id_readRR2, id_isMulDiv,
        input  ex_memRead, ex_wAddr, ex_branchTaken, statClear,
        output pcWrite, ifidWrite, ifidFlush, idexFlush, muldivBusy, ctrlState, stallCount
    );
endinterface

// File: rtl/hazard_stall_ctrl.sv
// Pipeline sequencer for the 5-stage CPU: load-use bubbles, mul/div front-end freeze,
// taken-branch squash, and a saturating stall-cycle counter.
module hazard_stall_ctrl #(
    parameter int unsigned MULDIV_CYCLES = 4
) (
    input  logic               clock,
    input  logic               reset,
    hazard_stall_ctrl_if.slave bus
);

    localparam int unsigned CNT_W   = 8;
    localparam int unsigned STALL_W = 16;

    typedef enum logic [1:0] {
        ST_RUN        = 2'd0,
        ST_LOAD_STALL = 2'd1,
        ST_MULDIV     = 2'd2
    } state_e;

    state_e              state_q, state_d;
    logic [CNT_W-1:0]    cnt_q, cnt_d;
    logic [STALL_W-1:0]  stall_cnt_q, stall_cnt_d;

    logic luh_c;
    logic pc_write_c;
    logic ifid_write_c;
    logic ifid_flush_c;
    logic idex_flush_c;
    logic muldiv_busy_c;

    // Load-use hazard: the load in EX writes a register the ID instruction reads.
    always_comb begin
        luh_c = bus.id_valid & bus.ex_memRead &
                ((bus.id_readRR1 & (bus.id_RR1 == bus.ex_wAddr)) |
                 (bus.id_readRR2 & (bus.id_RR2 == bus.ex_wAddr)));
    end

    // Next-state and control-strobe decode.
    always_comb begin
        state_d       = state_q;
        cnt_d         = cnt_q;
        pc_write_c    = 1'b1;
        ifid_write_c  = 1'b1;
        ifid_flush_c  = 1'b0;
        idex_flush_c  = 1'b0;
        muldiv_busy_c = 1'b0;

        case (state_q)
            ST_RUN: begin
                if (bus.ex_branchTaken) begin
                    ifid_flush_c = 1'b1;
                    idex_flush_c = 1'b1;
                    state_d      = ST_RUN;
                end else if (luh_c) begin
                    pc_write_c   = 1'b0;
                    ifid_write_c = 1'b0;
                    idex_flush_c = 1'b1;
                    state_d      = ST_LOAD_STALL;
                end else if (bus.id_valid & bus.id_isMulDiv) begin
                    state_d = ST_MULDIV;
                    cnt_d   = CNT_W'(MULDIV_CYCLES - 1);
                end
            end

            // EX holds the bubble now, so the hazard cannot recur this cycle.
            ST_LOAD_STALL: begin
                if (bus.id_valid & bus.id_isMulDiv) begin
                    state_d = ST_MULDIV;
                    cnt_d   = CNT_W'(MULDIV_CYCLES - 1);
                end else begin
                    state_d = ST_RUN;
                end
            end

            ST_MULDIV: begin
                pc_write_c    = 1'b0;
                ifid_write_c  = 1'b0;
                idex_flush_c  = 1'b1;
                muldiv_busy_c = 1'b1;
                if (cnt_q != '0) begin
                    cnt_d = cnt_q - CNT_W'(1);
                end else begin
                    state_d = ST_RUN;
                end
            end

            default: begin
                state_d = ST_RUN;
            end
        endcase
    end

    // Saturating count of cycles with the PC frozen; clear wins over increment.
    always_comb begin
        stall_cnt_d = stall_cnt_q;
        if (bus.statClear) begin
            stall_cnt_d = '0;
        end else if (!pc_write_c && (stall_cnt_q != '1)) begin
            stall_cnt_d = stall_cnt_q + STALL_W'(1);
        end
    end

    // State, mul/div down-counter and stall counter registers.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q     <= ST_RUN;
            cnt_q       <= '0;
            stall_cnt_q <= '0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            stall_cnt_q <= stall_cnt_d;
        end
    end

    // Strobes act in the detection cycle; held at the RUN-idle values while in reset.
    assign bus.pcWrite    = reset ? pc_write_c    : 1'b1;
    assign bus.ifidWrite  = reset ? ifid_write_c  : 1'b1;
    assign bus.ifidFlush  = reset ? ifid_flush_c  : 1'b0;
    assign bus.idexFlush  = reset ? idex_flush_c  : 1'b0;
    assign bus.muldivBusy = reset ? muldiv_busy_c : 1'b0;
    assign bus.ctrlState  = state_q;
    assign bus.stallCount = stall_cnt_q;

endmodule

// File: tb/tb_hazard_stall_ctrl.sv
// Directed bench for hazard_stall_ctrl: one task per scenario, inline expected values.
module tb_hazard_stall_ctrl;

    logic clock;
    logic reset;
    int   total;
    int   bad;

    hazard_stall_ctrl_if bus ();
    hazard_stall_ctrl_if bus_b ();

    hazard_stall_ctrl #(.MULDIV_CYCLES(4)) dut (
        .clock (clock),
        .reset (reset),
        .bus   (bus)
    );

    // Second instance at the longest legal mul/div latency, used for counter saturation.
    hazard_stall_ctrl #(.MULDIV_CYCLES(255)) dut_b (
        .clock (clock),
        .reset (reset),
        .bus   (bus_b)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    // A taken branch must never be presented while the mul/div unit owns EX.
    always @(posedge clock) begin
        assert (!(bus.muldivBusy === 1'b1 && bus.ex_branchTaken === 1'b1))
            else $error("FAIL branch_in_muldiv: ex_branchTaken=1 while muldivBusy=1");
    end

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    task automatic idle();
        bus.id_valid       = 1'b0;
        bus.id_RR1         = 4'd0;
        bus.id_RR2         = 4'd0;
        bus.id_readRR1     = 1'b0;
        bus.id_readRR2     = 1'b0;
        bus.id_isMulDiv    = 1'b0;
        bus.ex_memRead     = 1'b0;
        bus.ex_wAddr       = 4'd0;
        bus.ex_branchTaken = 1'b0;
        bus.statClear      = 1'b0;
    endtask

    task automatic clear_stats();
        bus.statClear = 1'b1;
        step();
        bus.statClear = 1'b0;
    endtask

    task automatic set_luh_rr1();
        bus.id_valid   = 1'b1;
        bus.ex_memRead = 1'b1;
        bus.ex_wAddr   = 4'd3;
        bus.id_RR1     = 4'd3;
        bus.id_readRR1 = 1'b1;
    endtask

    task automatic test_reset();
        #1;
        total++;
        if (bus.ctrlState !== 2'd0 || bus.pcWrite !== 1'b1 || bus.ifidWrite !== 1'b1 ||
            bus.ifidFlush !== 1'b0 || bus.idexFlush !== 1'b0 || bus.muldivBusy !== 1'b0) begin
            bad++;
            $display("FAIL reset_outputs: state=%0d pcw=%b ifw=%b iff=%b ief=%b busy=%b, want 0 1 1 0 0 0",
                     bus.ctrlState, bus.pcWrite, bus.ifidWrite, bus.ifidFlush, bus.idexFlush, bus.muldivBusy);
        end
        total++;
        if (bus.stallCount !== 16'd0) begin
            bad++;
            $display("FAIL reset_stallcount: got %0d want 0", bus.stallCount);
        end
        #20;
        reset = 1'b1;
        step();
        total++;
        if (bus.ctrlState !== 2'd0 || bus.pcWrite !== 1'b1) begin
            bad++;
            $display("FAIL reset_release: state=%0d pcw=%b want 0 1", bus.ctrlState, bus.pcWrite);
        end
    endtask

    task automatic test_load_use();
        idle();
        clear_stats();
        set_luh_rr1();
        #1;
        total++;
        if (bus.pcWrite !== 1'b0 || bus.ifidWrite !== 1'b0 || bus.idexFlush !== 1'b1 ||
            bus.ifidFlush !== 1'b0 || bus.ctrlState !== 2'd0) begin
            bad++;
            $display("FAIL luh_detect: pcw=%b ifw=%b ief=%b iff=%b state=%0d want 0 0 1 0 0",
                     bus.pcWrite, bus.ifidWrite, bus.idexFlush, bus.ifidFlush, bus.ctrlState);
        end
        step();
        // Inputs held: LOAD_STALL must not re-detect the hazard.
        total++;
        if (bus.ctrlState !== 2'd1 || bus.pcWrite !== 1'b1 || bus.ifidWrite !== 1'b1 ||
            bus.idexFlush !== 1'b0 || bus.stallCount !== 16'd1) begin
            bad++;
            $display("FAIL luh_stall_cycle: state=%0d pcw=%b ifw=%b ief=%b cnt=%0d want 1 1 1 0 1",
                     bus.ctrlState, bus.pcWrite, bus.ifidWrite, bus.idexFlush, bus.stallCount);
        end
        idle();
        step();
        total++;
        if (bus.ctrlState !== 2'd0 || bus.stallCount !== 16'd1) begin
            bad++;
            $display("FAIL luh_return: state=%0d cnt=%0d want 0 1", bus.ctrlState, bus.stallCount);
        end
        // Hazard through the second source port.
        bus.id_valid   = 1'b1;
        bus.ex_memRead = 1'b1;
        bus.ex_wAddr   = 4'd9;
        bus.id_RR1     = 4'd5;
        bus.id_readRR1 = 1'b1;
        bus.id_RR2     = 4'd9;
        bus.id_readRR2 = 1'b1;
        #1;
        total++;
        if (bus.pcWrite !== 1'b0 || bus.idexFlush !== 1'b1) begin
            bad++;
            $display("FAIL luh_rr2: pcw=%b ief=%b want 0 1", bus.pcWrite, bus.idexFlush);
        end
        step();
        idle();
        step();
        total++;
        if (bus.ctrlState !== 2'd0 || bus.stallCount !== 16'd2) begin
            bad++;
            $display("FAIL luh_rr2_return: state=%0d cnt=%0d want 0 2", bus.ctrlState, bus.stallCount);
        end
    endtask

    task automatic test_no_hazard();
        idle();
        clear_stats();
        set_luh_rr1();
        bus.id_readRR1 = 1'b0;
        #1;
        total++;
        if (bus.pcWrite !== 1'b1 || bus.idexFlush !== 1'b0) begin
            bad++;
            $display("FAIL nohz_noread: pcw=%b ief=%b want 1 0", bus.pcWrite, bus.idexFlush);
        end
        step();
        bus.id_readRR1 = 1'b1;
        bus.ex_wAddr   = 4'd4;
        #1;
        total++;
        if (bus.pcWrite !== 1'b1 || bus.ifidWrite !== 1'b1 || bus.idexFlush !== 1'b0) begin
            bad++;
            $display("FAIL nohz_addr: pcw=%b ifw=%b ief=%b want 1 1 0", bus.pcWrite, bus.ifidWrite, bus.idexFlush);
        end
        step();
        total++;
        if (bus.ctrlState !== 2'd0 || bus.stallCount !== 16'd0) begin
            bad++;
            $display("FAIL nohz_state: state=%0d cnt=%0d want 0 0", bus.ctrlState, bus.stallCount);
        end
        idle();
    endtask

    task automatic test_branch();
        idle();
        clear_stats();
        set_luh_rr1();
        bus.id_isMulDiv    = 1'b1;
        bus.ex_branchTaken = 1'b1;
        #1;
        total++;
        if (bus.ifidFlush !== 1'b1 || bus.idexFlush !== 1'b1 || bus.pcWrite !== 1'b1 || bus.ifidWrite !== 1'b1) begin
            bad++;
            $display("FAIL branch_squash: iff=%b ief=%b pcw=%b ifw=%b want 1 1 1 1",
                     bus.ifidFlush, bus.idexFlush, bus.pcWrite, bus.ifidWrite);
        end
        step();
        bus.ex_branchTaken = 1'b0;
        bus.id_isMulDiv    = 1'b0;
        bus.ex_memRead     = 1'b0;
        total++;
        if (bus.ctrlState !== 2'd0 || bus.stallCount !== 16'd0) begin
            bad++;
            $display("FAIL branch_state: state=%0d cnt=%0d want 0 0", bus.ctrlState, bus.stallCount);
        end
        idle();
    endtask

    task automatic test_muldiv();
        idle();
        clear_stats();
        bus.id_valid    = 1'b1;
        bus.id_isMulDiv = 1'b1;
        #1;
        total++;
        if (bus.pcWrite !== 1'b1 || bus.idexFlush !== 1'b0 || bus.muldivBusy !== 1'b0) begin
            bad++;
            $display("FAIL md_issue: pcw=%b ief=%b busy=%b want 1 0 0", bus.pcWrite, bus.idexFlush, bus.muldivBusy);
        end
        step();
        for (int i = 0; i < 4; i++) begin
            total++;
            if (bus.muldivBusy !== 1'b1 || bus.pcWrite !== 1'b0 || bus.ifidWrite !== 1'b0 ||
                bus.idexFlush !== 1'b1 || bus.ifidFlush !== 1'b0 || bus.ctrlState !== 2'd2) begin
                bad++;
                $display("FAIL md_freeze[%0d]: busy=%b pcw=%b ifw=%b ief=%b iff=%b state=%0d want 1 0 0 1 0 2",
                         i, bus.muldivBusy, bus.pcWrite, bus.ifidWrite, bus.idexFlush, bus.ifidFlush, bus.ctrlState);
            end
            step();
        end
        total++;
        if (bus.ctrlState !== 2'd0 || bus.stallCount !== 16'd4 || bus.pcWrite !== 1'b1) begin
            bad++;
            $display("FAIL md_done: state=%0d cnt=%0d pcw=%b want 0 4 1", bus.ctrlState, bus.stallCount, bus.pcWrite);
        end
        // Next ID instruction is also mul/div: straight back into MULDIV.
        step();
        bus.id_isMulDiv = 1'b0;
        total++;
        if (bus.ctrlState !== 2'd2 || bus.muldivBusy !== 1'b1) begin
            bad++;
            $display("FAIL md_back_to_back: state=%0d busy=%b want 2 1", bus.ctrlState, bus.muldivBusy);
        end
        for (int i = 0; i < 4; i++) step();
        total++;
        if (bus.ctrlState !== 2'd0 || bus.stallCount !== 16'd8) begin
            bad++;
            $display("FAIL md_b2b_done: state=%0d cnt=%0d want 0 8", bus.ctrlState, bus.stallCount);
        end
        idle();
    endtask

    task automatic test_load_use_muldiv();
        idle();
        clear_stats();
        set_luh_rr1();
        bus.id_isMulDiv = 1'b1;
        #1;
        total++;
        if (bus.pcWrite !== 1'b0 || bus.idexFlush !== 1'b1) begin
            bad++;
            $display("FAIL luhmd_bubble: pcw=%b ief=%b want 0 1", bus.pcWrite, bus.idexFlush);
        end
        step();
        bus.ex_memRead = 1'b0;
        total++;
        if (bus.ctrlState !== 2'd1 || bus.pcWrite !== 1'b1) begin
            bad++;
            $display("FAIL luhmd_stall: state=%0d pcw=%b want 1 1", bus.ctrlState, bus.pcWrite);
        end
        step();
        bus.id_isMulDiv = 1'b0;
        total++;
        if (bus.ctrlState !== 2'd2 || bus.stallCount !== 16'd1) begin
            bad++;
            $display("FAIL luhmd_enter: state=%0d cnt=%0d want 2 1", bus.ctrlState, bus.stallCount);
        end
        for (int i = 0; i < 4; i++) step();
        total++;
        if (bus.ctrlState !== 2'd0 || bus.stallCount !== 16'd5) begin
            bad++;
            $display("FAIL luhmd_done: state=%0d cnt=%0d want 0 5", bus.ctrlState, bus.stallCount);
        end
        idle();
    endtask

    task automatic test_reset_mid_muldiv();
        idle();
        bus.id_valid    = 1'b1;
        bus.id_isMulDiv = 1'b1;
        step();
        bus.id_isMulDiv = 1'b0;
        step();
        total++;
        if (bus.ctrlState !== 2'd2 || bus.stallCount === 16'd0) begin
            bad++;
            $display("FAIL rstmd_pre: state=%0d cnt=%0d want 2 nonzero", bus.ctrlState, bus.stallCount);
        end
        reset = 1'b0;
        #1;
        total++;
        if (bus.ctrlState !== 2'd0 || bus.muldivBusy !== 1'b0 || bus.pcWrite !== 1'b1 ||
            bus.idexFlush !== 1'b0 || bus.stallCount !== 16'd0) begin
            bad++;
            $display("FAIL rstmd_async: state=%0d busy=%b pcw=%b ief=%b cnt=%0d want 0 0 1 0 0",
                     bus.ctrlState, bus.muldivBusy, bus.pcWrite, bus.idexFlush, bus.stallCount);
        end
        idle();
        #3;
        reset = 1'b1;
        step();
        total++;
        if (bus.ctrlState !== 2'd0 || bus.stallCount !== 16'd0) begin
            bad++;
            $display("FAIL rstmd_release: state=%0d cnt=%0d want 0 0", bus.ctrlState, bus.stallCount);
        end
    endtask

    task automatic test_saturation();
        int n;
        bus_b.id_valid    = 1'b1;
        bus_b.id_isMulDiv = 1'b1;
        n = 0;
        while (bus_b.stallCount !== 16'hFFFF && n < 80000) begin
            step();
            n++;
        end
        total++;
        if (bus_b.stallCount !== 16'hFFFF) begin
            bad++;
            $display("FAIL sat_reach: cnt=%0h after %0d cycles want ffff", bus_b.stallCount, n);
        end
        for (int i = 0; i < 4500; i++) step();
        total++;
        if (bus_b.stallCount !== 16'hFFFF) begin
            bad++;
            $display("FAIL sat_hold: cnt=%0h want ffff", bus_b.stallCount);
        end
        bus_b.statClear = 1'b1;
        step();
        bus_b.statClear   = 1'b0;
        bus_b.id_isMulDiv = 1'b0;
        total++;
        if (bus_b.stallCount !== 16'd0) begin
            bad++;
            $display("FAIL sat_clear: cnt=%0h want 0", bus_b.stallCount);
        end
    endtask

    initial begin
        total = 0;
        bad   = 0;
        reset = 1'b0;
        idle();
        bus_b.id_valid       = 1'b0;
        bus_b.id_RR1         = 4'd0;
        bus_b.id_RR2         = 4'd0;
        bus_b.id_readRR1     = 1'b0;
        bus_b.id_readRR2     = 1'b0;
        bus_b.id_isMulDiv    = 1'b0;
        bus_b.ex_memRead     = 1'b0;
        bus_b.ex_wAddr       = 4'd0;
        bus_b.ex_branchTaken = 1'b0;
        bus_b.statClear      = 1'b0;

        test_reset();
        test_load_use();
        test_no_hazard();
        test_branch();
        test_muldiv();
        test_load_use_muldiv();
        test_reset_mid_muldiv();
        test_saturation();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
